// File: rtl/spi_cmd_dispatch.sv
// SPI command dispatcher: synchronises the frame event, queues commands, drives framebuffer writes.
// Optional CMD_STATS_EN builds a saturating counter of rejected/overflowed commands.
module spi_cmd_dispatch #(
  parameter int unsigned GRID_W     = 32,
  parameter int unsigned GRID_H     = 24,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic [23:0]                   cmd_in,
  input  logic                          cmd_ready,
  output logic                          fb_we,
  output logic [ADDR_W-1:0]             fb_addr,
  output logic [7:0]                    fb_data,
  input  logic                          fb_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW = 1 + ADDR_W + 8;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(GRID_W * GRID_H - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

  // CS idles high, so the chain resets to 1 to avoid a false frame edge.
  logic s1_q, s2_q, s3_q;
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= cmd_ready;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  logic frame;
  assign frame = s2_q & ~s3_q;

  logic [7:0]        cmd_x, cmd_y, cmd_d;
  logic              is_clear, is_pixel, push_req;
  logic [ADDR_W-1:0] pix_addr;
  logic [EntW-1:0]   push_entry;

  assign cmd_x    = cmd_in[23:16];
  assign cmd_y    = cmd_in[15:8];
  assign cmd_d    = cmd_in[7:0];
  assign is_clear = (cmd_x == 8'hFF);
  assign is_pixel = (32'(cmd_x) < GRID_W) && (32'(cmd_y) < GRID_H);
  assign pix_addr = ADDR_W'(cmd_y) * ADDR_W'(GRID_W) + ADDR_W'(cmd_x);
  assign push_req = frame & (is_clear | is_pixel);
  assign push_entry = {is_clear, is_clear ? '0 : pix_addr, cmd_d};

  // Command FIFO
  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            full, empty, push, pop, ovf_drop;
  state_e          state_q, state_d;

  assign full     = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == StIdle) & ~empty;
  assign push     = push_req & (~full | pop);
  assign ovf_drop = push_req & full & ~pop;

  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_drop) overflow <= 1'b1;
    end
  end

  assign fifo_level = count_q;

  logic [EntW-1:0]   pop_entry;
  logic              pop_clear;
  logic [ADDR_W-1:0] pop_addr;
  logic [7:0]        pop_data;

  assign pop_entry = mem_q[rd_ptr_q];
  assign pop_clear = pop_entry[EntW-1];
  assign pop_addr  = pop_entry[EntW-2:8];
  assign pop_data  = pop_entry[7:0];

  // Dispatch FSM
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_data_q, fb_data_d;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fb_we_d   = fb_we_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          fb_we_d   = 1'b1;
          fb_data_d = pop_data;
          if (pop_clear) begin
            fb_addr_d = '0;
            state_d   = StClear;
          end else begin
            fb_addr_d = pop_addr;
            state_d   = StWrite;
          end
        end
      end
      StWrite: begin
        if (!fb_busy) begin
          fb_we_d = 1'b0;
          state_d = StIdle;
        end
      end
      StClear: begin
        if (!fb_busy) begin
          if (fb_addr_q == LastAddr) begin
            fb_we_d = 1'b0;
            state_d = StIdle;
          end else begin
            fb_addr_d = fb_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;

`ifdef CMD_STATS_EN
  logic       drop_event;
  logic [7:0] drop_q;
  assign drop_event = (frame & ~(is_clear | is_pixel)) | ovf_drop;
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      drop_q <= 8'd0;
    end else if (drop_event && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end
  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Directed bench for spi_cmd_dispatch: vector table for single commands plus
// hand sequences for clear sweep, stalls, overflow and mid-clear reset.
module tb_spi_cmd_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [23:0] cmd_in = 24'h0;
  logic       cmd_ready = 1'b1;
  logic       fb_busy = 1'b0;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       overflow;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int exp_drops = 0;

`ifdef CMD_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t writes[$];

  typedef struct {
    logic [23:0] cmd;
    bit          ok;
    logic [9:0]  addr;
  } vec_t;
  vec_t vecs[9];

  spi_cmd_dispatch dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .cmd_in     (cmd_in),
    .cmd_ready  (cmd_ready),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_busy    (fb_busy),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A write completes on the coming edge when fb_we=1 and fb_busy=0.
  always @(negedge clk) begin
    if (!rst && fb_we && !fb_busy) writes.push_back('{cyc, fb_addr, fb_data});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Frame: CS low for 3 cycles then high; returns after the push edge.
  task automatic send(input logic [23:0] c);
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    cmd_in    = c;
    repeat (3) @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    rise_cyc  = cyc;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int bad;
    logic [9:0] a;
    logic [7:0] d;

    vecs[0] = '{24'h05032A, 1'b1, 10'd101};
    vecs[1] = '{24'h000011, 1'b1, 10'd0};
    vecs[2] = '{24'h1F17C3, 1'b1, 10'd767};
    vecs[3] = '{24'h200001, 1'b0, 10'd0};
    vecs[4] = '{24'h001801, 1'b0, 10'd0};
    vecs[5] = '{24'h10025A, 1'b1, 10'd80};
    vecs[6] = '{24'hFE0009, 1'b0, 10'd0};
    vecs[7] = '{24'h001701, 1'b1, 10'd736};
    vecs[8] = '{24'h1F0066, 1'b1, 10'd31};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fb_data", 32'(fb_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_fifo_level", 32'(fifo_level), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_no_write", writes.size(), 0);

    // Single-command vectors
    for (int i = 0; i < 9; i++) begin
      writes.delete();
      send(vecs[i].cmd);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_nwrites", i), writes.size(), vecs[i].ok ? 1 : 0);
      if (writes.size() > 0) begin
        chk($sformatf("vec%0d_latency", i), writes[0].cyc - rise_cyc, 4);
        chk($sformatf("vec%0d_addr", i), 32'(writes[0].addr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_data", i), 32'(writes[0].data), 32'(vecs[i].cmd[7:0]));
      end
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 0);
      chk($sformatf("vec%0d_we_low", i), 32'(fb_we), 0);
      if (!vecs[i].ok) exp_drops++;
    end
    chk("drop_count_rejects", 32'(drop_count), Stats ? exp_drops : 0);

    // Full-screen clear
    writes.delete();
    send(24'hFF0007);
    t = 0;
    @(negedge clk);
    while (!fb_we && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("clear_start", 32'(fb_we), 1);
    bad = 0;
    for (int i = 0; i < 768; i++) begin
      if (fb_we !== 1'b1 || fb_addr !== 10'(i) || fb_data !== 8'h07) bad++;
      @(negedge clk);
    end
    chk("clear_sweep_errors", bad, 0);
    chk("clear_end_we", 32'(fb_we), 0);
    chk("clear_nwrites", writes.size(), 768);
    repeat (3) @(negedge clk);
    chk("clear_idle_we", 32'(fb_we), 0);

    // Stall mid-write
    @(posedge clk); #1;
    fb_busy = 1'b1;
    writes.delete();
    send(24'h0A043C);
    t = 0;
    @(negedge clk);
    while (!fb_we && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stall_we_seen", 32'(fb_we), 1);
    a = fb_addr;
    d = fb_data;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (fb_we !== 1'b1 || fb_addr !== a || fb_data !== d) bad++;
    end
    chk("stall_hold_errors", bad, 0);
    chk("stall_addr", 32'(a), 138);
    chk("stall_data", 32'(d), 32'h3C);
    @(posedge clk); #1;
    fb_busy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_nwrites", writes.size(), 1);
    chk("stall_we_low", 32'(fb_we), 0);

    // Overflow while framebuffer stalled
    fb_busy = 1'b1;
    writes.delete();
    for (int i = 0; i < 6; i++) send({8'(i), 8'h01, 8'(8'h40 + i)});
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_held_addr", 32'(fb_addr), 32);
    exp_drops++;
    chk("ovf_drop_count", 32'(drop_count), Stats ? exp_drops : 0);
    fb_busy = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("ovf_nwrites", writes.size(), 5);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < writes.size()) begin
        if (writes[i].addr !== 10'(32 + i) || writes[i].data !== 8'(8'h40 + i)) bad++;
      end
    end
    chk("ovf_order_errors", bad, 0);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_level_drained", 32'(fifo_level), 0);

    // Reset in the middle of a clear
    send(24'hFF0033);
    send(24'h020144);
    chk("rc_queued_level", 32'(fifo_level), 1);
    t = 0;
    @(negedge clk);
    while (fb_addr !== 10'd300 && t < 800) begin
      @(negedge clk);
      t++;
    end
    chk("rc_reached_300", 32'(fb_addr), 300);
    rst = 1'b1;
    #1;
    chk("rc_we_async", 32'(fb_we), 0);
    chk("rc_level", 32'(fifo_level), 0);
    chk("rc_overflow", 32'(overflow), 0);
    chk("rc_drop_count", 32'(drop_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    writes.delete();
    send(24'h030255);
    repeat (4) @(posedge clk);
    #1;
    chk("rc_post_nwrites", writes.size(), 1);
    if (writes.size() > 0) begin
      chk("rc_post_addr", 32'(writes[0].addr), 67);
      chk("rc_post_data", 32'(writes[0].data), 32'h55);
      chk("rc_post_latency", writes[0].cyc - rise_cyc, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_dispatch.md
Name: spi_cmd_dispatch

Overview:
Downstream consumer of the SPI receive stage. It takes the 24-bit {x, y, data} command word and the chip-select-derived ready flag, and brings the frame-complete event into the system clock domain. Accepted commands are queued in a small FIFO, then dispatched as single-cell framebuffer writes, or as a full-screen clear sweep, to the game framebuffer.

Parameters:
GRID_W, 32, framebuffer columns; x must be < GRID_W
GRID_H, 24, framebuffer rows; y must be < GRID_H
ADDR_W, 10, framebuffer address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H
FIFO_DEPTH, 4, command queue entries; power of two, at least 2

Ports:
CLOCK_50  in  1  system clock, rising-edge
RESET  in  1  asynchronous, active-high reset
cmd_in  in  24  {x[23:16], y[15:8], data[7:0]} from SPI stage; asynchronous to CLOCK_50, stable while cmd_ready is high
cmd_ready  in  1  SPI chip select; a rising edge marks a completed 24-bit frame
fb_we  out  1  framebuffer write request (valid)
fb_addr  out  ADDR_W  write address = y*GRID_W + x
fb_data  out  8  write data
fb_busy  in  1  framebuffer stall; a write completes on an edge where fb_we=1 and fb_busy=0
overflow  out  1  sticky; a command was lost because the FIFO was full
fifo_level  out  clog2(FIFO_DEPTH)+1  current queue occupancy
drop_count  out  8  rejected-command counter (see Optional Feature)

Behaviour:
- Reset values: fb_we=0, fb_addr=0, fb_data=0, overflow=0, fifo_level=0, drop_count=0, FSM=IDLE. All three sync flops reset to 1, because CS idles high, so no spurious edge occurs after reset.
- Synchronizer chain: s1<=cmd_ready, s2<=s1, s3<=s2. The frame event is s2 & ~s3. cmd_in is sampled on the edge where the frame event is true.
- Latency: cmd_ready rises before edge N. The frame event is true between N+1 and N+2, and the push happens at N+2. With fb_busy=0 and the FSM in IDLE, the pop happens and fb_we=1 is registered at N+3.
- Classification at capture:
  - x==8'hFF: CLEAR command, always accepted; y is ignored.
  - x<GRID_W and y<GRID_H: PIXEL command, accepted.
  - Anything else: rejected; not pushed.
- FIFO push/pop rules:
  - Push when not full.
  - Push while full with no pop in the same cycle: command dropped, overflow<=1.
  - Push and pop in the same cycle when full: both accepted, level unchanged.
  - overflow clears only on RESET.
- FSM states:
  - IDLE: if FIFO is not empty, pop. PIXEL: load fb_addr and fb_data, fb_we<=1, go to WRITE. CLEAR: fb_addr<=0, fb_data<=data, fb_we<=1, go to CLEAR.
  - WRITE: hold fb_we, fb_addr and fb_data while fb_busy=1. On the edge with fb_busy=0: fb_we<=0, go to IDLE. There is always at least one idle cycle between pixel writes.
  - CLEAR: on each edge with fb_busy=0, advance fb_addr by 1. The edge that completes address GRID_W*GRID_H-1 sets fb_we<=0 and returns to IDLE. fb_addr never exceeds GRID_W*GRID_H-1. Total writes = GRID_W*GRID_H, with no gaps except fb_busy stalls.
- Queueing during dispatch: commands arriving during WRITE or CLEAR keep queueing; they are never dropped while the FIFO has space.
- Address arithmetic: computed at ADDR_W width, unsigned; y*GRID_W must not truncate.
- RESET mid-operation: fb_we drops immediately (asynchronous), the FIFO empties, and the FSM returns to IDLE. A partially completed clear is abandoned.

Optional Feature:
CMD_STATS_EN
- Defined: drop_count increments by 1 for each rejected (out-of-range) command and each overflow drop. It saturates at 8'hFF. If both events occur in the same cycle, it still adds only 1.
- Undefined: drop_count is tied to 0 and no counter logic is built. overflow behaves the same in both builds.

Test Plan:
- cmd_in=24'h05_03_2A, pulse cmd_ready low then high, fb_busy=0 -> exactly one fb_we cycle with fb_addr=101, fb_data=8'h2A, 4 edges after the rise.
- cmd_in=24'hFF_00_07 -> 768 consecutive fb_we cycles, fb_addr 0..767, fb_data=8'h07, then fb_we=0 and FSM in IDLE.
- cmd_in=24'h20_00_01 (x=32) and cmd_in=24'h00_18_01 (y=24) -> no fb_we, fifo_level stays 0. With CMD_STATS_EN, drop_count=2.
- Hold fb_busy=1 and send 6 valid pixel commands -> fifo_level holds at 4 (one in WRITE), overflow=1. Release fb_busy -> the first 5 commands are written in order.
- Hold fb_busy=1 for 3 cycles mid-write -> fb_we, fb_addr and fb_data remain constant; only one write is counted.
- Assert RESET in the middle of a CLEAR at address 300 -> fb_we=0 immediately, fifo_level=0. A new pixel command afterwards dispatches normally.
